// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M, Zicsr) registered decode stage with SYSTEM/FENCE/illegal serialisation
module decode_stage #(
  parameter int XLEN   = 32,
  parameter bit EN_M   = 1'b1,
  parameter bit EN_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_funct7b5,
  output logic            reg_write,
  output logic            alu_src,
  output logic            mem_write,
  output logic            mem_read,
  output logic            branch,
  output logic            jump,
  output logic            jalr,
  output logic            op1_src,
  output logic [1:0]      mem_to_reg,
  output logic [2:0]      alu_op,
  output logic            is_ecall,
  output logic            is_ebreak,
  output logic            csr_write,
  output logic            is_fence,
  output logic            illegal,
  input  logic            sys_done
);

  typedef enum logic {RUN, HOLD} state_t;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       op1_src;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_op;
    logic       is_ecall;
    logic       is_ebreak;
    logic       csr_write;
    logic       is_fence;
    logic       illegal;
  } ctrl_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] pc_q, imm_q, imm_d;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;
  logic            funct7b5_q;
  logic            ill_d, serialize_d, accept;

  logic [4:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = in_instr[6:2];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    ctrl_d = '0;
    imm_d  = '0;
    ill_d  = 1'b0;
    unique case (opc)
      OPC_OP: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 3'b010;
        if (f7 == 7'b0000001) begin
          if (EN_M) ctrl_d.alu_op = 3'b110;
          else      ill_d = 1'b1;
        end else if (f7 != 7'b0000000 && f7 != 7'b0100000) begin
          ill_d = 1'b1;
        end
      end
      OPC_OPIMM: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 3'b011;
        imm_d            = imm_i;
      end
      OPC_LOAD: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 2'b01;
        imm_d             = imm_i;
      end
      OPC_STORE: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        imm_d            = imm_s;
      end
      OPC_BRANCH: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.alu_src = 1'b1;
        ctrl_d.alu_op  = 3'b001;
        imm_d          = imm_b;
      end
      OPC_JAL: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.op1_src    = 1'b1;
        ctrl_d.mem_to_reg = 2'b10;
        imm_d             = imm_j;
      end
      OPC_JALR: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.jalr       = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 2'b10;
        imm_d             = imm_i;
      end
      OPC_LUI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 3'b101;
        imm_d            = imm_u;
      end
      OPC_AUIPC: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.op1_src   = 1'b1;
        imm_d            = imm_u;
      end
      OPC_SYSTEM: begin
        imm_d = imm_i;
        if (f3 == 3'b000) begin
          ctrl_d.is_ecall  = ~in_instr[20];
          ctrl_d.is_ebreak = in_instr[20];
        end else if (EN_CSR) begin
          ctrl_d.csr_write = 1'b1;
          ctrl_d.reg_write = 1'b1;
        end else begin
          ill_d = 1'b1;
        end
      end
      OPC_MISC: begin
        ctrl_d.is_fence = 1'b1;
        imm_d           = imm_i;
      end
      default: ill_d = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) ill_d = 1'b1;
    // Illegal encodings must not leak any side-effecting control to execute.
    if (ill_d) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
    end
  end

  assign serialize_d = ill_d || (opc == OPC_SYSTEM) || (opc == OPC_MISC);

  assign in_ready = rst_n && (state_q == RUN) && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    state_d = state_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      if (accept)                    valid_d = 1'b1;
      else if (valid_q && out_ready) valid_d = 1'b0;
      unique case (state_q)
        RUN:  if (accept && serialize_d) state_d = HOLD;
        HOLD: if (sys_done)              state_d = RUN;
        default:                         state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      if (accept) begin
        ctrl_q     <= ctrl_d;
        pc_q       <= in_pc;
        imm_q      <= imm_d;
        rs1_q      <= in_instr[19:15];
        rs2_q      <= in_instr[24:20];
        rd_q       <= in_instr[11:7];
        funct3_q   <= f3;
        funct7b5_q <= in_instr[30];
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_imm      = imm_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_funct3   = funct3_q;
  assign out_funct7b5 = funct7b5_q;
  assign reg_write    = ctrl_q.reg_write;
  assign alu_src      = ctrl_q.alu_src;
  assign mem_write    = ctrl_q.mem_write;
  assign mem_read     = ctrl_q.mem_read;
  assign branch       = ctrl_q.branch;
  assign jump         = ctrl_q.jump;
  assign jalr         = ctrl_q.jalr;
  assign op1_src      = ctrl_q.op1_src;
  assign mem_to_reg   = ctrl_q.mem_to_reg;
  assign alu_op       = ctrl_q.alu_op;
  assign is_ecall     = ctrl_q.is_ecall;
  assign is_ebreak    = ctrl_q.is_ebreak;
  assign csr_write    = ctrl_q.csr_write;
  assign is_fence     = ctrl_q.is_fence;
  assign illegal      = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed-vector bench for decode_stage (EN_M=1 main instance, EN_M=0 side instance)
module tb_decode_stage;

  logic        clk, rst_n, flush, in_valid, out_ready, sys_done;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_funct7b5;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_funct3, alu_op;
  logic [1:0]  mem_to_reg;
  logic        reg_write, alu_src, mem_write, mem_read, branch, jump, jalr, op1_src;
  logic        is_ecall, is_ebreak, csr_write, is_fence, illegal;

  logic        m0_in_ready, m0_out_valid, m0_out_funct7b5;
  logic [31:0] m0_out_pc, m0_out_imm;
  logic [4:0]  m0_out_rs1, m0_out_rs2, m0_out_rd;
  logic [2:0]  m0_out_funct3, m0_alu_op;
  logic [1:0]  m0_mem_to_reg;
  logic        m0_reg_write, m0_alu_src, m0_mem_write, m0_mem_read, m0_branch, m0_jump, m0_jalr, m0_op1_src;
  logic        m0_is_ecall, m0_is_ebreak, m0_csr_write, m0_is_fence, m0_illegal;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] ADDI  = 32'h00510093;
  localparam logic [31:0] ADDI2 = 32'h00A10113;
  localparam logic [31:0] LUI   = 32'h123452B7;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] EBRK  = 32'h00100073;
  localparam logic [31:0] JALN4 = 32'hFFDFF0EF;
  localparam logic [31:0] MUL   = 32'h022081B3;

  decode_stage #(.XLEN(32), .EN_M(1'b1), .EN_CSR(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .reg_write(reg_write), .alu_src(alu_src),
    .mem_write(mem_write), .mem_read(mem_read), .branch(branch), .jump(jump), .jalr(jalr),
    .op1_src(op1_src), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .is_ecall(is_ecall),
    .is_ebreak(is_ebreak), .csr_write(csr_write), .is_fence(is_fence), .illegal(illegal),
    .sys_done(sys_done)
  );

  decode_stage #(.XLEN(32), .EN_M(1'b0), .EN_CSR(1'b1)) u_dut_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m0_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m0_out_valid), .out_ready(out_ready),
    .out_pc(m0_out_pc), .out_imm(m0_out_imm), .out_rs1(m0_out_rs1), .out_rs2(m0_out_rs2),
    .out_rd(m0_out_rd), .out_funct3(m0_out_funct3), .out_funct7b5(m0_out_funct7b5),
    .reg_write(m0_reg_write), .alu_src(m0_alu_src), .mem_write(m0_mem_write),
    .mem_read(m0_mem_read), .branch(m0_branch), .jump(m0_jump), .jalr(m0_jalr),
    .op1_src(m0_op1_src), .mem_to_reg(m0_mem_to_reg), .alu_op(m0_alu_op),
    .is_ecall(m0_is_ecall), .is_ebreak(m0_is_ebreak), .csr_write(m0_csr_write),
    .is_fence(m0_is_fence), .illegal(m0_illegal), .sys_done(sys_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [17:0] ctrl_vec();
    return {reg_write, alu_src, mem_write, mem_read, branch, jump, jalr, op1_src,
            mem_to_reg, alu_op, is_ecall, is_ebreak, csr_write, is_fence, illegal};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; sys_done = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_ctrl", ctrl_vec(), 0);

    // addi, then back-to-back throughput
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h100;
    #1 chk("addi_in_ready", in_ready, 1);
    @(negedge clk);
    chk("addi_valid", out_valid, 1);
    chk("addi_reg_write", reg_write, 1);
    chk("addi_alu_src", alu_src, 1);
    chk("addi_alu_op", alu_op, 3'b011);
    chk("addi_rs1", out_rs1, 2);
    chk("addi_rd", out_rd, 1);
    chk("addi_imm", out_imm, 5);
    chk("addi_pc", out_pc, 32'h100);
    in_instr = ADDI2; in_pc = 32'h104;
    #1 chk("tput_in_ready", in_ready, 1);
    @(negedge clk);
    chk("tput_valid", out_valid, 1);
    chk("tput_imm", out_imm, 10);
    chk("tput_pc", out_pc, 32'h104);

    // lui followed by a 3-cycle stall
    in_instr = LUI; in_pc = 32'h108;
    @(negedge clk);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_alu_op", alu_op, 3'b101);
    chk("lui_rd", out_rd, 5);
    out_ready = 1'b0; in_instr = ADDI; in_pc = 32'h10C;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall_in_ready", in_ready, 0);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_imm", out_imm, 32'h12345000);
      chk("stall_pc", out_pc, 32'h108);
    end
    out_ready = 1'b1;
    #1 chk("rise_in_ready", in_ready, 1);
    @(negedge clk);
    chk("rise_pc", out_pc, 32'h10C);
    chk("rise_imm", out_imm, 5);

    // ecall serialises until sys_done
    in_instr = ECALL; in_pc = 32'h110;
    @(negedge clk);
    chk("ecall_flag", is_ecall, 1);
    chk("ecall_reg_write", reg_write, 0);
    chk("ecall_valid", out_valid, 1);
    in_instr = EBRK; in_pc = 32'h114;
    #1 chk("hold_in_ready", in_ready, 0);
    @(negedge clk);
    chk("hold_drained", out_valid, 0);
    chk("hold_in_ready2", in_ready, 0);
    sys_done = 1'b1;
    #1 chk("hold_done_same_cycle", in_ready, 0);
    @(negedge clk);
    sys_done = 1'b0;
    #1 chk("release_in_ready", in_ready, 1);
    @(negedge clk);
    chk("ebreak_flag", is_ebreak, 1);
    chk("ebreak_not_ecall", is_ecall, 0);
    chk("ebreak_pc", out_pc, 32'h114);
    in_valid = 1'b0; sys_done = 1'b1;
    @(negedge clk);
    sys_done = 1'b0;
    #1 chk("ebreak_release", in_ready, 1);
    sys_done = 1'b1;
    @(negedge clk);
    sys_done = 1'b0;
    chk("run_done_valid", out_valid, 0);
    #1 chk("run_done_in_ready", in_ready, 1);

    // jal with negative offset
    in_valid = 1'b1; in_instr = JALN4; in_pc = 32'h120;
    @(negedge clk);
    chk("jal_imm", out_imm, 32'hFFFFFFFC);
    chk("jal_jump", jump, 1);
    chk("jal_mem_to_reg", mem_to_reg, 2'b10);
    chk("jal_op1_src", op1_src, 1);
    chk("jal_reg_write", reg_write, 1);

    // mul: legal with M, illegal and serialising without
    in_instr = MUL; in_pc = 32'h124;
    @(negedge clk);
    chk("mul_alu_op", alu_op, 3'b110);
    chk("mul_reg_write", reg_write, 1);
    chk("mul_illegal", illegal, 0);
    chk("m0_mul_illegal", m0_illegal, 1);
    chk("m0_mul_reg_write", m0_reg_write, 0);
    chk("m0_mul_valid", m0_out_valid, 1);
    in_valid = 1'b0;
    #1 chk("mul_in_ready", in_ready, 1);
    chk("m0_mul_hold", m0_in_ready, 0);

    // all-ones word, then flush out of HOLD
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h200;
    @(negedge clk);
    chk("ill_flag", illegal, 1);
    chk("ill_ctrl", ctrl_vec(), 18'h1);
    chk("ill_pc", out_pc, 32'h200);
    chk("ill_valid", out_valid, 1);
    in_valid = 1'b0;
    #1 chk("ill_hold", in_ready, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
    #1 chk("flush_in_ready", in_ready, 1);

    // flush coincident with a presented instruction
    in_valid = 1'b1; in_instr = ADDI; in_pc = 32'h300; flush = 1'b1;
    #1 chk("flush_blocks_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_drop_valid", out_valid, 0);

    // async reset during a stall
    in_valid = 1'b1; in_instr = LUI; in_pc = 32'h400; out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_pc", out_pc, 32'h400);
    @(negedge clk);
    chk("pre_rst_stall", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_imm", out_imm, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_ctrl", ctrl_vec(), 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage for the RV32I core, with optional M and Zicsr support.
- Accepts instruction/PC from fetch over valid/ready.
- Produces a one-cycle-latency registered control and operand bundle to execute over valid/ready.
- Generates sign-extended immediates and flags illegal encodings.
- Serialises SYSTEM/FENCE/illegal instructions by stalling until execute reports completion.

Parameters:
XLEN, 32, datapath/PC/immediate width (32 or 64)
EN_M, 1, 1 = decode RV32M (funct7=0000001 on OP); 0 = those encodings are illegal
EN_CSR, 1, 1 = decode Zicsr (SYSTEM, funct3!=000); 0 = those encodings are illegal

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  kill contents and any serialisation hold (branch/trap redirect)
in_valid  in  1  fetch has instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  bundle valid to execute
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  registered PC
out_imm  out  XLEN  sign-extended immediate
out_rs1, out_rs2, out_rd  out  5 each  register indices
out_funct3  out  3  instr[14:12]
out_funct7b5  out  1  instr[30]
reg_write, alu_src, mem_write, mem_read, branch, jump, jalr, op1_src  out  1 each  control, same meaning as existing core
mem_to_reg  out  2  00=ALU, 01=MEM, 10=PC+4
alu_op  out  3  000 add, 001 branch, 010 R, 011 I-ALU, 101 LUI, 110 MULDIV
is_ecall, is_ebreak, csr_write, is_fence, illegal  out  1 each  system/exception flags
sys_done  in  1  one-cycle pulse: execute has retired the held instruction

Behaviour:
- Reset (rst_n=0, async):
  - All outputs 0.
  - State = RUN.
  - in_ready is 0 only while rst_n=0.
- State machine: RUN, HOLD.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
- Accept when in_valid && in_ready:
  - Next edge: out_valid=1 and all bundle fields take the decode of in_instr/in_pc.
  - Latency is exactly 1 cycle.
- Drain when out_valid && out_ready with no accept in the same cycle: out_valid=0 next edge. Bundle fields keep their old values.
- Stall when out_valid && !out_ready: every output holds stable.
- Flush (highest priority):
  - Next edge: out_valid=0 and state=RUN.
  - An instruction presented in the flush cycle is not accepted.
  - A sys_done in the same cycle is irrelevant.
- Serialisation:
  - Accepting SYSTEM (opcode 1110011), FENCE (0001111) or any illegal instruction moves RUN->HOLD.
  - HOLD->RUN on sys_done=1. sys_done in RUN is ignored.
  - A HOLD->RUN transition and a new accept cannot occur in the same cycle, because in_ready is evaluated on the current state.
- Decode by opcode[6:2], control values as in the existing core:
  - OP: reg_write, alu_op=010. If funct7=0000001 and EN_M, alu_op=110.
  - OP-IMM: alu_src, reg_write, alu_op=011.
  - LOAD: alu_src, reg_write, mem_read, mem_to_reg=01.
  - STORE: alu_src, mem_write.
  - BRANCH: branch, alu_src, alu_op=001.
  - JAL: jump, reg_write, alu_src, op1_src, mem_to_reg=10.
  - JALR: jump, jalr, alu_src, reg_write, mem_to_reg=10.
  - LUI: alu_src, reg_write, alu_op=101.
  - AUIPC: alu_src, reg_write, op1_src.
  - SYSTEM: funct3=000 gives is_ecall (instr[20]=0) or is_ebreak (instr[20]=1); otherwise csr_write and reg_write.
  - MISC-MEM: is_fence only.
- Immediate: selected by format I/S/B/U/J, sign-extended from instr[31] to XLEN. U-type = {instr[31:12], 12'b0} sign-extended. R-type gives 0.
- Illegal when any of the following hold:
  - instr[1:0] != 11;
  - opcode not in the list above;
  - OP with funct7 not in {0000000, 0100000, 0000001 (if EN_M)};
  - CSR encoding with EN_CSR=0.
- Illegal handling: illegal=1, all write/mem/branch/jump controls 0, out_pc valid.
- Reset asserted mid-operation: immediate return to reset values, any HOLD discarded.

Test Plan:
- Reset, then in_instr=0x00510093 (addi x1,x2,5), in_pc=0x100, out_ready=1 -> next cycle out_valid=1, reg_write=1, alu_src=1, alu_op=011, rs1=2, rd=1, out_imm=5, out_pc=0x100; with in_valid=1 every cycle, throughput is 1/cycle.
- 0x123452B7 (lui x5,0x12345) with out_ready=0 for 3 cycles -> out_imm=0x12345000, alu_op=101; in_ready=0 and outputs stable for 3 cycles; a second instruction is accepted on the cycle out_ready rises.
- 0x00000073 (ecall) -> is_ecall=1, reg_write=0, in_ready=0 until a sys_done pulse; 0x00100073 -> is_ebreak=1; sys_done while in RUN has no effect.
- 0x022081B3 (mul x3,x1,x2): with EN_M=1 -> alu_op=110, reg_write=1; with EN_M=0 -> illegal=1, reg_write=0, stage enters HOLD.
- 0xFFFFFFFF -> illegal=1 and all controls 0; flush during HOLD -> out_valid=0 and in_ready=1 on the next cycle.
- Assert flush in the same cycle as an accept, and separately drop rst_n mid-stall -> instruction dropped and out_valid=0; on reset all outputs read 0 asynchronously.
